// File: rtl/vga_sincronizador.sv
// vga_sincronizador: VGA 640x480@60 timing generator; pixel rate comes from an enable divider on clk.
// Syncs and areaAtiva are decoded from next-state counters so they never skew against coluna/linha.
module vga_sincronizador #(
    parameter int H_VISIVEL = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIVEL = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int DIV_PIXEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_en,
    output logic [9:0] coluna,
    output logic [9:0] linha,
    output logic       areaAtiva,
    output logic       hsync,
    output logic       vsync,
    output logic       fimQuadro
);
    localparam int DW = (DIV_PIXEL > 1) ? $clog2(DIV_PIXEL) : 1;
    localparam logic [9:0] H_MAX  = 10'(H_VISIVEL + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX  = 10'(V_VISIVEL + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIVEL);
    localparam logic [9:0] V_VIS  = 10'(V_VISIVEL);
    localparam logic [9:0] HS_INI = 10'(H_VISIVEL + H_FRONT);
    localparam logic [9:0] HS_FIM = 10'(H_VISIVEL + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_INI = 10'(V_VISIVEL + V_FRONT);
    localparam logic [9:0] VS_FIM = 10'(V_VISIVEL + V_FRONT + V_SYNC);

    logic [DW-1:0] divisor;
    logic [9:0]    col_nxt;
    logic [9:0]    lin_nxt;
    logic          fim_linha;
    logic          fim_quadro_nxt;

    assign pixel_en = divisor == DW'(DIV_PIXEL - 1);

    always_comb begin
        fim_linha      = pixel_en && coluna == H_MAX;
        fim_quadro_nxt = fim_linha && linha == V_MAX;
        col_nxt        = fim_linha ? '0 : coluna + 10'(pixel_en);
        lin_nxt        = fim_quadro_nxt ? '0 : linha + 10'(fim_linha);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor   <= '0;
            coluna    <= '0;
            linha     <= '0;
            areaAtiva <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            fimQuadro <= 1'b0;
        end else begin
            divisor   <= pixel_en ? '0 : divisor + DW'(1);
            coluna    <= col_nxt;
            linha     <= lin_nxt;
            areaAtiva <= col_nxt < H_VIS && lin_nxt < V_VIS;
            hsync     <= !(col_nxt >= HS_INI && col_nxt < HS_FIM);
            vsync     <= !(lin_nxt >= VS_INI && lin_nxt < VS_FIM);
            fimQuadro <= fim_quadro_nxt;
        end
    end
endmodule

// File: tb/tb_vga_sincronizador.sv
// tb_vga_sincronizador: two shrunken-frame instances (DIV 2 and 1) plus a default-size one,
// checked every cycle against an arithmetic position model derived from edges since reset.
module tb_vga_sincronizador;
    typedef struct packed {
        logic       pe;
        logic [9:0] col;
        logic [9:0] lin;
        logic       act;
        logic       hs;
        logic       vs;
        logic       fim;
    } out_t;
    typedef struct {
        int   k;
        out_t e;
    } vec_t;

    localparam int HV = 20, HF = 4, HS = 6, HB = 5, VV = 12, VF = 3, VS = 2, VB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pe_a, act_a, hs_a, vs_a, fim_a, pe_b, act_b, hs_b, vs_b, fim_b, pe_c, act_c, hs_c, vs_c, fim_c;
    logic [9:0] col_a, lin_a, col_b, lin_b, col_c, lin_c;
    out_t ga, gb, gc;
    int tests = 0, fails = 0, k = 0, last_a = -1, last_b = -1;
    vec_t tbl[12];

    always #5 clk = ~clk;

    vga_sincronizador #(.H_VISIVEL(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .V_VISIVEL(VV),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .DIV_PIXEL(2)) dut_a (
        .clk(clk), .rst(rst), .pixel_en(pe_a), .coluna(col_a), .linha(lin_a),
        .areaAtiva(act_a), .hsync(hs_a), .vsync(vs_a), .fimQuadro(fim_a));
    vga_sincronizador #(.H_VISIVEL(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .V_VISIVEL(VV),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .DIV_PIXEL(1)) dut_b (
        .clk(clk), .rst(rst), .pixel_en(pe_b), .coluna(col_b), .linha(lin_b),
        .areaAtiva(act_b), .hsync(hs_b), .vsync(vs_b), .fimQuadro(fim_b));
    vga_sincronizador dut_c (
        .clk(clk), .rst(rst), .pixel_en(pe_c), .coluna(col_c), .linha(lin_c),
        .areaAtiva(act_c), .hsync(hs_c), .vsync(vs_c), .fimQuadro(fim_c));

    assign ga = {pe_a, col_a, lin_a, act_a, hs_a, vs_a, fim_a};
    assign gb = {pe_b, col_b, lin_b, act_b, hs_b, vs_b, fim_b};
    assign gc = {pe_c, col_c, lin_c, act_c, hs_c, vs_c, fim_c};

    // k = clk edges since reset release (0 while in reset); position = completed pixel periods mod frame
    function automatic out_t model(input int kk, input int div, input int hv, input int hf, input int hs,
                                   input int hb, input int vv, input int vf, input int vs, input int vb);
        out_t o;
        int ht, vt, n, c, l;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        n = (kk / div) % (ht * vt);
        c = n % ht;
        l = n / ht;
        o.pe  = (kk == 0) ? (div == 1) : ((kk % div) == div - 1);
        o.col = 10'(c);
        o.lin = 10'(l);
        o.act = kk > 0 && c < hv && l < vv;
        o.hs  = !(kk > 0 && c >= hv + hf && c < hv + hf + hs);
        o.vs  = !(kk > 0 && l >= vv + vf && l < vv + vf + vs);
        o.fim = kk > 0 && (kk % div) == 0 && n == 0;
        return o;
    endfunction

    task automatic chk(input string nm, input out_t got, input out_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s k=%0d got pe=%b col=%0d lin=%0d act=%b hs=%b vs=%b fim=%b expected pe=%b col=%0d lin=%0d act=%b hs=%b vs=%b fim=%b",
                nm, k, got.pe, got.col, got.lin, got.act, got.hs, got.vs, got.fim,
                exp.pe, exp.col, exp.lin, exp.act, exp.hs, exp.vs, exp.fim);
        end
    endtask

    task automatic check_all();
        chk("A", ga, model(k, 2, HV, HF, HS, HB, VV, VF, VS, VB));
        chk("B", gb, model(k, 1, HV, HF, HS, HB, VV, VF, VS, VB));
        chk("C", gc, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        for (int i = 0; i < 12; i++)
            if (tbl[i].k == k) chk("C_vec", gc, tbl[i].e);
    endtask

    task automatic period(input string nm, input logic f, input int want, inout int last);
        if (f) begin
            if (last >= 0) begin
                tests++;
                if (k - last != want) begin
                    fails++;
                    $display("FAIL %s_period got %0d clks expected %0d", nm, k - last, want);
                end
            end
            last = k;
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_all();
        period("A", fim_a, 2 * 35 * 21, last_a);
        period("B", fim_b, 35 * 21, last_b);
    endtask

    initial begin
        out_t r;
        int n;
        //            k      pe    col      lin     act   hs    vs    fim
        tbl[0]  = '{1,    {1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[1]  = '{2,    {1'b0, 10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[2]  = '{4,    {1'b0, 10'd2,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[3]  = '{1279, {1'b1, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[4]  = '{1280, {1'b0, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[5]  = '{1311, {1'b1, 10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[6]  = '{1312, {1'b0, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[7]  = '{1503, {1'b1, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[8]  = '{1504, {1'b0, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[9]  = '{1599, {1'b1, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[10] = '{1600, {1'b0, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[11] = '{1601, {1'b1, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0}};
        repeat (3) @(negedge clk);
        check_all();
        r = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        chk("C_rst", gc, r);
        rst = 1'b0;
        repeat (3200) step();
        // random mid-cycle async resets: outputs must clear before any clk edge, then restart at (0,0)
        repeat (4) begin
            n = int'($urandom_range(100, 1600));
            repeat (n) step();
            #2 rst = 1'b1;
            #1 k = 0;
            last_a = -1;
            last_b = -1;
            check_all();
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
            check_all();
            rst = 1'b0;
        end
        repeat (1600) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_sincronizador.md
Name: vga_sincronizador

Overview:
- VGA 640x480@60 Hz timing generator; the first stage of the video path.
- Produces hsync/vsync for the connector.
- Produces linha, coluna and areaAtiva, which feed every drawing stage (grid, ship and shot layers) directly downstream.
- Derives the 25 MHz pixel rate from the system clock through an integer enable divider, so all logic stays on one clock.

Parameters:
H_VISIVEL, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIVEL, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
DIV_PIXEL, 2, system clocks per pixel (>=1); 2 gives 25 MHz from 50 MHz

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pixel_en  out  1  high on the clk cycle whose rising edge advances the pixel counters
coluna  out  10  current horizontal position, 0..H_TOTAL-1
linha  out  10  current vertical position, 0..V_TOTAL-1
areaAtiva  out  1  1 while coluna<H_VISIVEL and linha<V_VISIVEL
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
fimQuadro  out  1  one-clk pulse at the start of each new frame

Behaviour:
- Derived totals:
  - H_TOTAL = H_VISIVEL+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_VISIVEL+V_FRONT+V_SYNC+V_BACK (525).
- Reset is one clock domain with an async-assert, active-high rst. While rst=1:
  - divider=0, coluna=0, linha=0.
  - hsync=1, vsync=1, areaAtiva=0, fimQuadro=0.
  - pixel_en follows the divider decode: 0 for DIV_PIXEL>1, 1 for DIV_PIXEL=1.
- Divider:
  - Counts 0..DIV_PIXEL-1 and wraps.
  - pixel_en = (divider==DIV_PIXEL-1), decoded from the divider register.
  - DIV_PIXEL=1: pixel_en is constantly 1 outside reset.
- Pixel counters advance only on rising edges where pixel_en=1:
  - coluna==H_TOTAL-1: coluna->0, and linha increments.
  - Otherwise coluna+1.
  - linha==V_TOTAL-1 at line wrap: linha->0.
  - All arithmetic is 10-bit unsigned; no value >= H_TOTAL or >= V_TOTAL may ever appear.
- Registered decode of hsync, vsync and areaAtiva:
  - Updated every clk edge from the next-state counter values.
  - All three are always coherent with the linha/coluna presented in the same cycle; zero skew between position and syncs.
  - On the first edge after reset release they become the decode of (0,0): areaAtiva=1, hsync=1, vsync=1.
- Sync windows:
  - hsync=0 iff H_VISIVEL+H_FRONT <= coluna < H_VISIVEL+H_FRONT+H_SYNC (656..751).
  - vsync=0 iff V_VISIVEL+V_FRONT <= linha < V_VISIVEL+V_FRONT+V_SYNC (490..491), for every coluna on those lines.
- fimQuadro:
  - Registered; 1 for exactly one clk, the first cycle in which (linha,coluna)=(0,0) after a wrap from (V_TOTAL-1,H_TOTAL-1).
  - Not asserted for the (0,0) presented immediately after reset.
  - With DIV_PIXEL>1 it is not repeated on the remaining clocks of that pixel.
- Timing:
  - Latency from reset release to the first counter advance is DIV_PIXEL clk edges.
  - Frame period is H_TOTAL*V_TOTAL*DIV_PIXEL clocks (840000 at defaults).
- Reset mid-frame: all state returns immediately, asynchronously, to reset values. Timing restarts from (0,0); no partial-line resume.
- No external enable or stall; the block free-runs after reset.

Test Plan:
1. Reset then release, DIV_PIXEL=2:
   - During reset: coluna=0, linha=0, hsync=1, vsync=1, areaAtiva=0.
   - Edge 1: areaAtiva=1, pixel_en=1.
   - Edge 2: coluna=1.
   - Edge 4: coluna=2.
2. Run one line:
   - hsync falls when coluna becomes 656 and rises when coluna becomes 752 (96 pixels = 192 clks).
   - areaAtiva falls at coluna=640.
   - After coluna=799, the next values are coluna=0 and linha=1.
3. Run a full frame:
   - vsync is low exactly while linha=490..491 (1600 pixels).
   - areaAtiva=0 for all linha>=480.
   - (524,799) -> (0,0) with fimQuadro high for 1 clk.
   - The next fimQuadro comes exactly 840000 clks later.
4. Over two frames, coherence holds every cycle:
   - areaAtiva == (coluna<640 && linha<480).
   - hsync and vsync match their window formulas.
   - coluna<800 and linha<525 at all times.
5. Assert rst at linha=300, coluna=400, between clock edges:
   - Outputs go to reset values without waiting for a clk edge.
   - After release, timing restarts from (0,0) with no fimQuadro.
6. DIV_PIXEL=1:
   - pixel_en is constantly 1.
   - coluna increments every clk.
   - Frame period is 420000 clks; sync windows are unchanged in pixel units.
